// File: rtl/echo_ranger_pkg.sv
// Shared FSM encoding and default 50 MHz timing constants for the echo ranger.
package echo_ranger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_e;

    localparam int DEF_W              = 32;
    localparam int DEF_TRIG_CYCLES    = 500;
    localparam int DEF_TIMEOUT_CYCLES = 1_250_000;
    localparam int DEF_HOLDOFF_CYCLES = 500_000;
    localparam int DEF_CYCLES_PER_CM  = 2900;

    // Phase timer width; covers every default cycle count with room to spare.
    localparam int CNT_W = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; 2 cycles latency, no backpressure.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/echo_ranger.sv
// Ultrasonic ranger: trigger pulse, echo high-time measurement with timeout and holdoff.
// Results are registered strobes; no backpressure. ECHO_RANGER_DISTANCE_EN adds distance_cm.
module echo_ranger
    import echo_ranger_pkg::*;
#(
    parameter int W              = DEF_W,
    parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int CYCLES_PER_CM  = DEF_CYCLES_PER_CM
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         continuous,
    input  logic         echo,
    output logic         trig,
    output logic [W-1:0] echo_duration,
    output logic         valid,
    output logic         timeout,
    output logic         busy
`ifdef ECHO_RANGER_DISTANCE_EN
    ,
    output logic [W-1:0] distance_cm
`endif
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HO_LAST   = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [W-1:0]     MEAS_MAX  = '1;

    if (W < 1 || TRIG_CYCLES < 1 || TIMEOUT_CYCLES < 1 || HOLDOFF_CYCLES < 1 || CYCLES_PER_CM < 1)
    begin : g_bad_cfg
        $error("echo_ranger: width and cycle parameters must be >= 1");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     meas_q, meas_d;
    logic [W-1:0]     dur_q, dur_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             trig_q;
    logic             echo_s, echo_prev_q;
    logic             rise;

    sync_2ff #(.WIDTH(1)) u_echo_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (echo),
        .q_o   (echo_s)
    );

    // A level already high on entry to WAIT_RISE never produces a rise.
    assign rise = echo_s & ~echo_prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        meas_d    = meas_q;
        dur_d     = dur_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start || continuous) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                    meas_d  = W'(1);
                    cnt_d   = cnt_q + 1'b1;
                end else if (cnt_q >= TO_LAST) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                // Echo fall wins over a coincident timeout so the strobes stay exclusive.
                if (!echo_s) begin
                    state_d = ST_HOLDOFF;
                    dur_d   = meas_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q >= TO_LAST) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (meas_q != MEAS_MAX) meas_d = meas_q + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q >= HO_LAST) begin
                    if (!echo_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            meas_q      <= '0;
            dur_q       <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            trig_q      <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            meas_q      <= meas_d;
            dur_q       <= dur_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            trig_q      <= (state_d == ST_TRIG);
            echo_prev_q <= echo_s;
        end
    end

    assign trig          = trig_q;
    assign echo_duration = dur_q;
    assign valid         = valid_q;
    assign timeout       = timeout_q;
    assign busy          = (state_q != ST_IDLE);

`ifdef ECHO_RANGER_DISTANCE_EN
    localparam logic [CNT_W-1:0] CPC_LAST = CNT_W'(CYCLES_PER_CM - 1);

    logic [CNT_W-1:0] sub_q, sub_d, sub_base;
    logic [W-1:0]     acc_q, acc_d, acc_base;
    logic [W-1:0]     dist_q, dist_d;
    logic             rise_start;
    logic             step;

    // Every echo-high cycle counted by meas_q also advances the centimetre sub-counter.
    always_comb begin
        rise_start = (state_q == ST_WAIT_RISE) && rise;
        step       = rise_start || ((state_q == ST_MEASURE) && echo_s && (cnt_q < TO_LAST));
        sub_base   = rise_start ? '0 : sub_q;
        acc_base   = rise_start ? '0 : acc_q;
        sub_d      = sub_q;
        acc_d      = acc_q;
        dist_d     = dist_q;
        if (step) begin
            if (sub_base == CPC_LAST) begin
                sub_d = '0;
                acc_d = (acc_base == MEAS_MAX) ? acc_base : acc_base + 1'b1;
            end else begin
                sub_d = sub_base + 1'b1;
                acc_d = acc_base;
            end
        end
        if (valid_d) dist_d = acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q  <= '0;
            acc_q  <= '0;
            dist_q <= '0;
        end else begin
            sub_q  <= sub_d;
            acc_q  <= acc_d;
            dist_q <= dist_d;
        end
    end

    assign distance_cm = dist_q;
`endif

endmodule

// File: tb/tb_echo_ranger.sv
// Directed bench for echo_ranger with shortened timing parameters.
module tb_echo_ranger;

    localparam int W      = 32;
    localparam int TRIG_C = 50;
    localparam int TO_C   = 6000;
    localparam int HO_C   = 1000;
    localparam int CPC    = 290;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         start      = 1'b0;
    logic         continuous = 1'b0;
    logic         echo       = 1'b0;
    logic         trig, valid, timeout, busy;
    logic [W-1:0] echo_duration;
`ifdef ECHO_RANGER_DISTANCE_EN
    logic [W-1:0] distance_cm;
`endif

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int valid_cnt = 0, timeout_cnt = 0, both_cnt = 0, trig_rise_cnt = 0;
    int valid_cyc = 0, timeout_cyc = 0, trig_rise_cyc = 0, trig_fall_cyc = 0;
    logic trig_prev = 1'b0;

    always #5 clk = ~clk;

    echo_ranger #(
        .W              (W),
        .TRIG_CYCLES    (TRIG_C),
        .TIMEOUT_CYCLES (TO_C),
        .HOLDOFF_CYCLES (HO_C),
        .CYCLES_PER_CM  (CPC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .continuous    (continuous),
        .echo          (echo),
        .trig          (trig),
        .echo_duration (echo_duration),
        .valid         (valid),
        .timeout       (timeout),
        .busy          (busy)
`ifdef ECHO_RANGER_DISTANCE_EN
        ,
        .distance_cm   (distance_cm)
`endif
    );

    always @(negedge clk) begin
        cyc++;
        if (valid === 1'b1) begin valid_cnt++; valid_cyc = cyc; end
        if (timeout === 1'b1) begin timeout_cnt++; timeout_cyc = cyc; end
        if (valid === 1'b1 && timeout === 1'b1) both_cnt++;
        if (trig === 1'b1 && trig_prev === 1'b0) begin trig_rise_cnt++; trig_rise_cyc = cyc; end
        if (trig === 1'b0 && trig_prev === 1'b1) trig_fall_cyc = cyc;
        trig_prev = trig;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        echo  = 1'b0;
        repeat (3) tick();
        checks++; if (trig !== 1'b0) begin failures++; $display("FAIL reset_trig: got %b want 0", trig); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (echo_duration !== 32'd0) begin failures++; $display("FAIL reset_duration: got %0d want 0", echo_duration); end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset: busy=%b want 0", busy); end
    endtask

    task automatic test_single();
        int n;
        int v0, t0;
        pulse_start();
        checks++; if (trig !== 1'b1) begin failures++; $display("FAIL trig_next_cycle: got %b want 1", trig); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_in_trig: got %b want 1", busy); end
        n = 1;
        while (trig === 1'b1 && n < 1000) begin
            tick();
            if (trig === 1'b1) n++;
        end
        checks++; if (n !== TRIG_C) begin failures++; $display("FAIL trig_width: got %0d want %0d", n, TRIG_C); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_wait_rise: got %b want 1", busy); end
        repeat (10) tick();
        v0 = valid_cnt;
        t0 = timeout_cnt;
        echo = 1'b1;
        repeat (2500) tick();
        echo = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: busy=%b want 0", busy); end
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL single_valid_count: got %0d want 1", valid_cnt - v0); end
        checks++; if (timeout_cnt - t0 !== 0) begin failures++; $display("FAIL single_timeout_count: got %0d want 0", timeout_cnt - t0); end
        checks++; if (echo_duration !== 32'd2500) begin failures++; $display("FAIL single_duration: got %0d want 2500", echo_duration); end
`ifdef ECHO_RANGER_DISTANCE_EN
        checks++; if (distance_cm !== 32'd8) begin failures++; $display("FAIL single_distance: got %0d want 8", distance_cm); end
`endif
    endtask

    task automatic test_continuous();
        int n, v0, r0, vc, gap;
        v0 = valid_cnt;
        continuous = 1'b1;
        n = 0;
        while (trig !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (trig !== 1'b1) begin failures++; $display("FAIL cont_auto_trig: got %b want 1", trig); end
        n = 0;
        while (trig !== 1'b0 && n < 200) begin tick(); n++; end
        repeat (20) tick();
        echo = 1'b1;
        repeat (5000) tick();
        echo = 1'b0;
        n = 0;
        while (valid_cnt == v0 && n < 20) begin tick(); n++; end
        checks++; if (echo_duration !== 32'd5000) begin failures++; $display("FAIL cont_duration1: got %0d want 5000", echo_duration); end
        vc = valid_cyc;
        r0 = trig_rise_cnt;
        n = 0;
        while (trig_rise_cnt == r0 && n < HO_C + 50) begin tick(); n++; end
        gap = trig_rise_cyc - vc;
        checks++;
        if (trig_rise_cnt == r0 || gap < HO_C || gap > HO_C + 5) begin
            failures++;
            $display("FAIL cont_holdoff_gap: got %0d cycles want %0d..%0d", gap, HO_C, HO_C + 5);
        end
        continuous = 1'b0;
        n = 0;
        while (trig !== 1'b0 && n < 200) begin tick(); n++; end
        repeat (20) tick();
        echo = 1'b1;
        repeat (1000) tick();
        echo = 1'b0;
        n = 0;
        while (valid_cnt == v0 + 1 && n < 20) begin tick(); n++; end
        checks++; if (echo_duration !== 32'd1000) begin failures++; $display("FAIL cont_duration2: got %0d want 1000", echo_duration); end
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cont_stops: busy=%b want 0", busy); end
        checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("FAIL cont_valid_count: got %0d want 2", valid_cnt - v0); end
    endtask

    task automatic test_timeout();
        int n, v0, t0, r0;
        logic [W-1:0] d0;
        d0 = echo_duration;
        v0 = valid_cnt;
        t0 = timeout_cnt;
        pulse_start();
        n = 0;
        while (trig !== 1'b0 && n < 200) begin tick(); n++; end
        n = 0;
        while (timeout_cnt == t0 && n < TO_C + 100) begin tick(); n++; end
        checks++; if (timeout_cyc - trig_fall_cyc !== TO_C) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", timeout_cyc - trig_fall_cyc, TO_C); end
        r0 = trig_rise_cnt;
        pulse_start();
        checks++; if (busy !== 1'b1 || trig !== 1'b0) begin failures++; $display("FAIL start_in_holdoff: busy=%b trig=%b want 1/0", busy, trig); end
        n = 0;
        while (busy !== 1'b0 && n < HO_C + 100) begin tick(); n++; end
        repeat (30) tick();
        checks++; if (trig_rise_cnt !== r0) begin failures++; $display("FAIL start_not_queued: rises=%0d want %0d", trig_rise_cnt, r0); end
        checks++; if (timeout_cnt - t0 !== 1) begin failures++; $display("FAIL timeout_count: got %0d want 1", timeout_cnt - t0); end
        checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL timeout_no_valid: got %0d want %0d", valid_cnt, v0); end
        checks++; if (echo_duration !== d0) begin failures++; $display("FAIL timeout_duration_kept: got %0d want %0d", echo_duration, d0); end
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL valid_timeout_overlap: got %0d want 0", both_cnt); end
    endtask

    task automatic test_held_echo();
        int n, v0;
        echo = 1'b1;
        repeat (5) tick();
        v0 = valid_cnt;
        pulse_start();
        n = 0;
        while (trig !== 1'b0 && n < 200) begin tick(); n++; end
        repeat (200) tick();
        checks++; if (valid_cnt !== v0 || busy !== 1'b1) begin failures++; $display("FAIL held_no_measure: valids=%0d busy=%b want %0d/1", valid_cnt, busy, v0); end
        echo = 1'b0;
        repeat (10) tick();
        echo = 1'b1;
        repeat (2900) tick();
        echo = 1'b0;
        n = 0;
        while (valid_cnt == v0 && n < 20) begin tick(); n++; end
        checks++; if (echo_duration !== 32'd2900) begin failures++; $display("FAIL held_duration: got %0d want 2900", echo_duration); end
`ifdef ECHO_RANGER_DISTANCE_EN
        checks++; if (distance_cm !== 32'd10) begin failures++; $display("FAIL held_distance: got %0d want 10", distance_cm); end
`endif
        n = 0;
        while (busy !== 1'b0 && n < HO_C + 100) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n, v0;
        pulse_start();
        n = 0;
        while (trig !== 1'b0 && n < 200) begin tick(); n++; end
        repeat (5) tick();
        echo = 1'b1;
        repeat (100) tick();
        v0 = valid_cnt;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (trig !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL midrst_strobes: trig=%b valid=%b timeout=%b want 0", trig, valid, timeout); end
        checks++; if (echo_duration !== 32'd0) begin failures++; $display("FAIL midrst_duration: got %0d want 0", echo_duration); end
`ifdef ECHO_RANGER_DISTANCE_EN
        checks++; if (distance_cm !== 32'd0) begin failures++; $display("FAIL midrst_distance: got %0d want 0", distance_cm); end
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        echo = 1'b0;
        repeat (100) tick();
        checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL midrst_no_valid: got %0d want %0d", valid_cnt, v0); end
        checks++; if (busy !== 1'b0 || echo_duration !== 32'd0) begin failures++; $display("FAIL midrst_after: busy=%b dur=%0d want 0/0", busy, echo_duration); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_timeout();
        test_held_echo();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
